// File: rtl/sipo_frame_ctrl.sv
// Frame sequencer for a free-running SIPO: gates WIDTH serial bits per frame, captures the word, offers it on valid/ready.
// Optional even-parity trailer bit per frame when SIPO_PARITY_EN is defined.
module sipo_frame_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic             ser_d,
  input  logic [WIDTH-1:0] sipo_q,
  output logic             sipo_d,
  output logic             sipo_reset,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun,
  input  logic             ovr_clr,
  output logic             parity_err
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             capture;
  logic             load;
  logic             drop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Abort outranks both the capture and a back-to-back start in DONE.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SHIFT;
          cnt_nxt   = '0;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
          if (cnt == CNT_LAST) state_nxt = DONE;
        end
      end
      DONE: begin
        if (abort) begin
          state_nxt = IDLE;
        end else begin
          capture = 1'b1;
          if (start) begin
            state_nxt = SHIFT;
            cnt_nxt   = '0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy       = (state != IDLE);
  assign sipo_reset = ~reset_n | (state == IDLE);
  assign sipo_d     = busy ? ser_d : 1'b0;

  // Single-entry output register: a capture lands only if the slot is free or drains this edge.
  assign load = capture & (~out_valid | out_ready);
  assign drop = capture & ~load;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (load) begin
        out_data  <= sipo_q;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (drop) begin
        overrun <= 1'b1;
      end else if (ovr_clr) begin
        overrun <= 1'b0;
      end
    end
  end

`ifdef SIPO_PARITY_EN
  // The parity bit arrives on ser_d during DONE, alongside the capture of the data word.
  function automatic logic parity_mismatch(input logic [WIDTH-1:0] word, input logic pbit);
    return (^word) ^ pbit;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      parity_err <= 1'b0;
    end else if (load) begin
      parity_err <= parity_mismatch(sipo_q, ser_d);
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule
